game_sprite_motion: RTL and testbench

Sprite motion engine: the receiving end of the game master's sprite control signals (write_xy, write_dxy, enable_update). It holds one sprite's position and velocity and advances the position once per update strobe while updates are enabled. It reports sprite_within_screen back to the game master and exposes the position to the sprite pixel renderer and the collision detector. One instance is used per sprite (target, torpedo).

---
 rtl/game_sprite_motion.sv | 116 +++++++++++
 tb/tb_game_sprite_motion.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sprite_motion.sv
// Sprite motion engine: holds one sprite's position/velocity and steps it on a periodic strobe.
// Optional build macro GAME_SPRITE_SUBPIXEL_EN adds 4 fractional position bits (velocity in 1/16 px).
module game_sprite_motion #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 10,
    parameter int DX_WIDTH      = 4,
    parameter int DY_WIDTH      = 4,
    parameter int SPRITE_WIDTH  = 8,
    parameter int SPRITE_HEIGHT = 8,
    parameter int STROBE_PERIOD = 1_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sprite_write_xy,
    input  logic                      sprite_write_dxy,
    input  logic signed [X_WIDTH:0]   sprite_write_x,
    input  logic signed [Y_WIDTH:0]   sprite_write_y,
    input  logic signed [DX_WIDTH-1:0] sprite_write_dx,
    input  logic signed [DY_WIDTH-1:0] sprite_write_dy,
    input  logic                      sprite_enable_update,
    output logic signed [X_WIDTH:0]   sprite_x,
    output logic signed [Y_WIDTH:0]   sprite_y,
    output logic                      sprite_within_screen,
    output logic                      sprite_moved
);

`ifdef GAME_SPRITE_SUBPIXEL_EN
    localparam int FRAC_W = 4;
`else
    localparam int FRAC_W = 0;
`endif
    localparam int XP_W  = X_WIDTH + 1 + FRAC_W;
    localparam int YP_W  = Y_WIDTH + 1 + FRAC_W;
    localparam int CNT_W = $clog2(STROBE_PERIOD);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_PERIOD - 1);

    // Bounds are compared one bit wider than the position so x + size cannot overflow.
    localparam logic signed [X_WIDTH+1:0] SCR_W_E = (X_WIDTH+2)'(SCREEN_WIDTH);
    localparam logic signed [X_WIDTH+1:0] SPR_W_E = (X_WIDTH+2)'(SPRITE_WIDTH);
    localparam logic signed [Y_WIDTH+1:0] SCR_H_E = (Y_WIDTH+2)'(SCREEN_HEIGHT);
    localparam logic signed [Y_WIDTH+1:0] SPR_H_E = (Y_WIDTH+2)'(SPRITE_HEIGHT);

    logic [CNT_W-1:0]          cnt_q,   cnt_d;
    logic signed [XP_W-1:0]    x_q,     x_d;
    logic signed [YP_W-1:0]    y_q,     y_d;
    logic signed [DX_WIDTH-1:0] dx_q,   dx_d;
    logic signed [DY_WIDTH-1:0] dy_q,   dy_d;
    logic                      moved_q, moved_d;

    logic                      strobe;
    logic                      do_update;
    logic signed [X_WIDTH+1:0] x_ext, x_end;
    logic signed [Y_WIDTH+1:0] y_ext, y_end;

    always_comb begin
        strobe    = (cnt_q == CNT_LAST);
        do_update = strobe & sprite_enable_update & ~sprite_write_xy;
        cnt_d     = strobe ? '0 : cnt_q + CNT_W'(1);

        x_d  = x_q;
        y_d  = y_q;
        dx_d = dx_q;
        dy_d = dy_q;

        // A position load wins over a same-cycle step; the step for that strobe is lost.
        if (sprite_write_xy) begin
            x_d = XP_W'(sprite_write_x) <<< FRAC_W;
            y_d = YP_W'(sprite_write_y) <<< FRAC_W;
        end else if (do_update) begin
            x_d = x_q + XP_W'(dx_q);
            y_d = y_q + YP_W'(dy_q);
        end

        // NOTE: the step above reads dx_q, so a same-cycle velocity load takes effect next strobe.
        if (sprite_write_dxy) begin
            dx_d = sprite_write_dx;
            dy_d = sprite_write_dy;
        end

        moved_d = do_update;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            moved_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            moved_q <= moved_d;
        end
    end

    assign sprite_x     = (X_WIDTH+1)'(x_q >>> FRAC_W);
    assign sprite_y     = (Y_WIDTH+1)'(y_q >>> FRAC_W);
    assign sprite_moved = moved_q;

    always_comb begin
        x_ext = (X_WIDTH+2)'(sprite_x);
        y_ext = (Y_WIDTH+2)'(sprite_y);
        x_end = x_ext + SPR_W_E;
        y_end = y_ext + SPR_H_E;
        sprite_within_screen = ~x_ext[X_WIDTH+1] & (x_end <= SCR_W_E)
                             & ~y_ext[Y_WIDTH+1] & (y_end <= SCR_H_E);
    end

endmodule

// File: tb/tb_game_sprite_motion.sv
// Directed bench for game_sprite_motion with a short strobe period and hand-computed positions.
module tb_game_sprite_motion;
    localparam int SP = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               sprite_write_xy;
    logic               sprite_write_dxy;
    logic signed [10:0] sprite_write_x;
    logic signed [10:0] sprite_write_y;
    logic signed [3:0]  sprite_write_dx;
    logic signed [3:0]  sprite_write_dy;
    logic               sprite_enable_update;
    logic signed [10:0] sprite_x;
    logic signed [10:0] sprite_y;
    logic               sprite_within_screen;
    logic               sprite_moved;

    int checks       = 0;
    int errors       = 0;
    int phase        = 0;
    int strobes_seen = 0;
    int moved_cnt    = 0;

    game_sprite_motion #(.STROBE_PERIOD(SP)) dut (
        .clk                  (clk),
        .reset                (reset),
        .sprite_write_xy      (sprite_write_xy),
        .sprite_write_dxy     (sprite_write_dxy),
        .sprite_write_x       (sprite_write_x),
        .sprite_write_y       (sprite_write_y),
        .sprite_write_dx      (sprite_write_dx),
        .sprite_write_dy      (sprite_write_dy),
        .sprite_enable_update (sprite_enable_update),
        .sprite_x             (sprite_x),
        .sprite_y             (sprite_y),
        .sprite_within_screen (sprite_within_screen),
        .sprite_moved         (sprite_moved)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // phase mirrors the strobe counter value during the current cycle.
    task automatic tick();
        logic rst_at_edge;
        @(posedge clk);
        rst_at_edge = reset;
        if (!rst_at_edge && phase == SP - 1) strobes_seen++;
        phase = rst_at_edge ? 0 : (phase + 1) % SP;
        #1;
        if (sprite_moved) moved_cnt++;
    endtask

    task automatic run_strobes(input int n);
        int target;
        target = strobes_seen + n;
        for (int i = 0; i < (n + 1) * SP && strobes_seen < target; i++) tick();
    endtask

    task automatic to_phase(input int p);
        for (int i = 0; i < SP && phase != p; i++) tick();
    endtask

    task automatic set_xy(input int x, input int y);
        sprite_write_xy = 1'b1;
        sprite_write_x  = 11'(x);
        sprite_write_y  = 11'(y);
    endtask

    task automatic set_dxy(input int dx, input int dy);
        sprite_write_dxy = 1'b1;
        sprite_write_dx  = 4'(dx);
        sprite_write_dy  = 4'(dy);
    endtask

    task automatic clear_writes();
        sprite_write_xy  = 1'b0;
        sprite_write_dxy = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        sprite_enable_update = 1'b0;
        sprite_write_x       = '0;
        sprite_write_y       = '0;
        sprite_write_dx      = '0;
        sprite_write_dy      = '0;
        clear_writes();
        tick();
        tick();
        reset = 1'b0;

        check("rst_x", int'(sprite_x), 0);
        check("rst_y", int'(sprite_y), 0);
        check("rst_moved", int'(sprite_moved), 0);
        check("rst_within", int'(sprite_within_screen), 1);

`ifdef GAME_SPRITE_SUBPIXEL_EN
        set_xy(100, 50);
        set_dxy(4, 0);
        sprite_enable_update = 1'b1;
        tick();
        clear_writes();
        check("sub_load_x", int'(sprite_x), 100);
        run_strobes(1);
        check("sub_s1_x", int'(sprite_x), 100);
        run_strobes(1);
        check("sub_s2_x", int'(sprite_x), 100);
        run_strobes(1);
        check("sub_s3_x", int'(sprite_x), 100);
        run_strobes(1);
        check("sub_s4_x", int'(sprite_x), 101);
        check("sub_s4_y", int'(sprite_y), 50);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("sub_rst_x", int'(sprite_x), 0);
        check("sub_rst_moved", int'(sprite_moved), 0);
`else
        // Basic motion: three strobes at (+3,-2).
        set_xy(100, 50);
        set_dxy(3, -2);
        sprite_enable_update = 1'b1;
        tick();
        clear_writes();
        check("load_x", int'(sprite_x), 100);
        check("load_y", int'(sprite_y), 50);
        moved_cnt = 0;
        run_strobes(3);
        check("mv3_x", int'(sprite_x), 109);
        check("mv3_y", int'(sprite_y), 44);
        check("mv3_pulses", moved_cnt, 3);
        check("mv3_within", int'(sprite_within_screen), 1);

        // Updates disabled.
        sprite_enable_update = 1'b0;
        set_dxy(5, 0);
        tick();
        clear_writes();
        moved_cnt = 0;
        run_strobes(5);
        check("dis_x", int'(sprite_x), 109);
        check("dis_y", int'(sprite_y), 44);
        check("dis_pulses", moved_cnt, 0);

        // Position write in a strobe cycle drops that update.
        set_dxy(4, 0);
        tick();
        clear_writes();
        sprite_enable_update = 1'b1;
        to_phase(SP - 1);
        set_xy(10, 10);
        tick();
        clear_writes();
        check("wxy_strobe_x", int'(sprite_x), 10);
        check("wxy_strobe_moved", int'(sprite_moved), 0);
        run_strobes(1);
        check("wxy_next_x", int'(sprite_x), 14);

        // Velocity write in a strobe cycle uses the old velocity once.
        set_xy(20, 10);
        set_dxy(1, 0);
        tick();
        clear_writes();
        to_phase(SP - 1);
        set_dxy(7, 0);
        tick();
        clear_writes();
        check("wdxy_old_x", int'(sprite_x), 21);
        check("wdxy_moved", int'(sprite_moved), 1);
        run_strobes(1);
        check("wdxy_new_x", int'(sprite_x), 28);

        // Right edge.
        set_xy(631, 10);
        set_dxy(1, 0);
        tick();
        clear_writes();
        check("r631_within", int'(sprite_within_screen), 1);
        run_strobes(1);
        check("r632_x", int'(sprite_x), 632);
        check("r632_within", int'(sprite_within_screen), 1);
        run_strobes(1);
        check("r633_x", int'(sprite_x), 633);
        check("r633_within", int'(sprite_within_screen), 0);

        // Left edge.
        set_xy(0, 10);
        set_dxy(-1, 0);
        tick();
        clear_writes();
        check("l0_within", int'(sprite_within_screen), 1);
        run_strobes(1);
        check("lm1_x", int'(sprite_x), -1);
        check("lm1_within", int'(sprite_within_screen), 0);

        // Bottom edge.
        set_xy(100, 472);
        set_dxy(0, 1);
        tick();
        clear_writes();
        check("b472_within", int'(sprite_within_screen), 1);
        run_strobes(1);
        check("b473_y", int'(sprite_y), 473);
        check("b473_within", int'(sprite_within_screen), 0);

        // Modulo wrap of the 11-bit signed position.
        set_xy(1023, 0);
        set_dxy(1, 0);
        tick();
        clear_writes();
        run_strobes(1);
        check("wrap_x", int'(sprite_x), -1024);

        // Reset in a strobe cycle discards the pending write and update.
        set_xy(50, 50);
        set_dxy(1, 1);
        tick();
        to_phase(SP - 1);
        set_xy(200, 200);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_writes();
        check("mrst_x", int'(sprite_x), 0);
        check("mrst_y", int'(sprite_y), 0);
        check("mrst_moved", int'(sprite_moved), 0);

        // First strobe lands SP-1 cycles after reset release.
        set_dxy(2, 0);
        tick();
        clear_writes();
        tick();
        tick();
        check("pre_strobe_x", int'(sprite_x), 0);
        tick();
        check("first_strobe_x", int'(sprite_x), 2);
        check("first_strobe_moved", int'(sprite_moved), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
